// File: rtl/ex_div_sequencer_pkg.sv
// Shared types for the EX-stage divide sequencer: default width and FSM state encoding.
package ex_div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_CALC   = 2'b01,
        DIV_FINISH = 2'b10
    } div_state_t;

endpackage

// File: rtl/ex_div_sequencer_div_iter_step.sv
// One restoring shift-subtract step: shifts {rem,quo} left by one and subtracts the divisor when it fits.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // The extra top bit keeps a shifted remainder of 2^WIDTH or more comparable against the divisor.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign rem_out = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    assign quo_out = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/ex_div_sequencer.sv
// Multi-cycle signed/unsigned divider controller for the EX stage.
// Optional build macro DIV_EARLY_EXIT_EN skips the iteration loop for zero divisors and small dividends.
module ex_div_sequencer
    import ex_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stallreq_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic             neg_quo;
    logic             neg_rem;
    logic             accept;
    logic             last_step;
`ifdef DIV_EARLY_EXIT_EN
    logic             early_exit;
`endif

    assign dividend_abs = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign divisor_abs  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    assign accept       = (state == DIV_IDLE) && start_i && !flush_i;
    assign last_step    = (state == DIV_CALC) && (cnt == CNT_W'(WIDTH - 1));
`ifdef DIV_EARLY_EXIT_EN
    assign early_exit   = (divisor_i == '0) || (dividend_abs < divisor_abs);
`endif

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = (state != DIV_IDLE);
        done_o     = (state == DIV_FINISH);
        stallreq_o = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    stallreq_o = 1'b1;
                    state_next = DIV_CALC;
`ifdef DIV_EARLY_EXIT_EN
                    if (early_exit) begin
                        state_next = DIV_FINISH;
                    end
`endif
                end
            end
            DIV_CALC: begin
                stallreq_o = 1'b1;
                if (last_step) begin
                    state_next = DIV_FINISH;
                end
            end
            DIV_FINISH: state_next = DIV_IDLE;
            default:    state_next = DIV_IDLE;
        endcase
        if (flush_i) begin
            state_next = DIV_IDLE;
        end
    end

    // A zero divisor leaves the all-ones quotient un-negated; the remainder sign always follows the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= dividend_abs;
            divisor <= divisor_abs;
            neg_quo <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]) && (divisor_i != '0);
            neg_rem <= signed_i && dividend_i[WIDTH-1];
`ifdef DIV_EARLY_EXIT_EN
            if (early_exit) begin
                quotient_o  <= (divisor_i == '0) ? '1 : '0;
                remainder_o <= dividend_i;
            end
`endif
        end else if (state == DIV_CALC) begin
            cnt <= cnt + 1'b1;
            rem <= rem_next;
            quo <= quo_next;
            if (last_step) begin
                quotient_o  <= neg_quo ? -quo_next : quo_next;
                remainder_o <= neg_rem ? -rem_next : rem_next;
            end
        end
    end

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Scoreboard bench for ex_div_sequencer: directed corner cases plus random operands against an arithmetic model.
module tb_ex_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        busy_o;
    logic        stallreq_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    ex_div_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .stallreq_o  (stallreq_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference arithmetic: truncating division, remainder sign follows the dividend.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r, output int lat);
`ifdef DIV_EARLY_EXIT_EN
        longint ma;
        longint mb;
`endif
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        lat = 33;
`ifdef DIV_EARLY_EXIT_EN
        ma = sgn ? longint'($signed(a)) : longint'(a);
        mb = sgn ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (b == 0 || ma < mb) lat = 1;
`endif
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_done: got done_o=1, expected no result (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("quotient", quotient_o, mon_e.q);
                check_output("remainder", remainder_o, mon_e.r);
                check_output("done_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  input bit hold_start);
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        bit          seen;
        ref_div(a, b, sgn, q, r, lat);
        @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = sgn;
        start_i    = 1'b1;
        #1;
        check_output("stall_accept", 32'(stallreq_o), 32'd1);
        check_output("busy_accept", 32'(busy_o), 32'd0);
        exp_q.push_back('{q: q, r: r, due: cyc + lat});
        seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen    = 1;
                start_i = 1'b0;
                #1;
                check_output("stall_finish", 32'(stallreq_o), 32'd0);
            end else begin
                check_output("stall_calc", 32'(stallreq_o), 32'd1);
                check_output("busy_calc", 32'(busy_o), 32'd1);
                if (i == 5) begin
                    check_output("hold_quotient", quotient_o, last_q);
                    check_output("hold_remainder", remainder_o, last_r);
                end
                if (hold_start) begin
                    start_i    = 1'b1;
                    dividend_i = $urandom;
                    divisor_i  = $urandom;
                    signed_i   = 1'($urandom);
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done_o within 40 cycles, expected done after %0d", lat);
            start_i = 1'b0;
        end
        last_q = q;
        last_r = r;
    endtask

    task automatic flush_mid_calc();
        @(negedge clk);
        dividend_i = 32'hFFFF_FFF0;
        divisor_i  = 32'd3;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check_output("flush_busy", 32'(busy_o), 32'd0);
        check_output("flush_done", 32'(done_o), 32'd0);
        check_output("flush_quotient", quotient_o, last_q);
        check_output("flush_remainder", remainder_o, last_r);
        @(negedge clk);
    endtask

    task automatic flush_beats_start();
        @(negedge clk);
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        flush_i    = 1'b1;
        #1;
        check_output("flush_start_stall", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check_output("flush_start_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic reset_mid_calc();
        @(negedge clk);
        dividend_i = 32'd123456;
        divisor_i  = 32'd789;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_output("rst_done", 32'(done_o), 32'd0);
        check_output("rst_quotient", quotient_o, 32'd0);
        check_output("rst_remainder", remainder_o, 32'd0);
        last_q = '0;
        last_r = '0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        flush_i    = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(busy_o), 32'd0);
        check_output("reset_done", 32'(done_o), 32'd0);
        check_output("reset_stall", 32'(stallreq_o), 32'd0);
        check_output("reset_quotient", quotient_o, 32'd0);
        check_output("reset_remainder", remainder_o, 32'd0);
        rst = 1'b0;

        apply_stimulus(32'd100, 32'd7, 1'b0, 0);
        apply_stimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        apply_stimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        apply_stimulus(32'd5, 32'd0, 1'b0, 0);
        apply_stimulus(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
        apply_stimulus(32'h8000_0000, 32'd1, 1'b1, 0);
        apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        apply_stimulus(32'd3, 32'd10, 1'b0, 0);

        flush_mid_calc();
        apply_stimulus(32'd1000, 32'd33, 1'b0, 0);
        flush_beats_start();

        apply_stimulus(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1);
        reset_mid_calc();

        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            apply_stimulus(a, b, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
